// File: rtl/date_seq_ctrl.sv
// date_seq_ctrl -- sequencing controller for a BCD day/month/year calendar.
// Turns the daily rollover pulse and the three user buttons into one-cycle
// registered control pulses for the external day, month and year counters,
// and walks the user through RUN -> SET_DAY -> SET_MONTH -> SET_YEAR -> CLAMP.
// Optional feature macro: AUTO_EXIT_EN (set modes time out after TIMEOUT_CYC
// cycles without a button edge and leave through CLAMP).
module date_seq_ctrl #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hour_carry,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic [3:0] day_unit,
  input  logic [1:0] day_ten,
  input  logic [3:0] month_unit,
  input  logic [0:0] month_ten,
  input  logic       leap,
  output logic       en_d,
  output logic       preset_d,
  output logic       up_d,
  output logic       down_d,
  output logic       en_m,
  output logic       up_m,
  output logic       down_m,
  output logic       up_y,
  output logic       down_y,
  output logic [1:0] mode
);

  typedef enum logic [2:0] {
    S_RUN,
    S_SET_DAY,
    S_SET_MONTH,
    S_SET_YEAR,
    S_CLAMP
  } state_e;

  // One bit per counter control; registered as a group so every pulse is
  // exactly one cycle wide and glitch-free.
  typedef struct packed {
    logic en_d;
    logic preset_d;
    logic up_d;
    logic down_d;
    logic en_m;
    logic up_m;
    logic down_m;
    logic up_y;
    logic down_y;
  } ctl_t;

  state_e     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic       pending_q, pending_d;
  logic [2:0] btn_q;

  logic [2:0] btn_now;
  logic [2:0] btn_edge;
  logic       mode_edge, up_edge, down_edge;
  logic       up_only, down_only;
  logic [5:0] day_bin;
  logic [4:0] month_bin;
  logic [5:0] month_len;
  logic       day_is_last;
  logic       day_is_first;
  logic       day_too_big;

  // Days in the given month; anything outside 1..12 is treated as 31 so a
  // corrupt month never forces a spurious preset.
  function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic lp);
    logic [5:0] len;
    len = 6'd31;
    case (m)
      5'd2:                      len = 6'd28 + {5'd0, lp};
      5'd4, 5'd6, 5'd9, 5'd11:   len = 6'd30;
      default:                   len = 6'd31;
    endcase
    return len;
  endfunction

  // Binary views of the BCD date, then the month-length comparisons.
  always_comb begin
    day_bin      = ({4'd0, day_ten} * 6'd10) + {2'd0, day_unit};
    month_bin    = ({4'd0, month_ten} * 5'd10) + {1'b0, month_unit};
    month_len    = days_in_month(month_bin, leap);
    day_is_last  = (day_bin == month_len);
    day_is_first = (day_bin == 6'd1);
    day_too_big  = (day_bin > month_len);
  end

  // Rising-edge detection against last cycle's button levels.
  assign btn_now   = {mode_btn, up_btn, down_btn};
  assign btn_edge  = btn_now & ~btn_q;
  assign mode_edge = btn_edge[2];
  assign up_edge   = btn_edge[1];
  assign down_edge = btn_edge[0];
  // A mode edge wins over up/down, and simultaneous up+down cancel out.
  assign up_only   = up_edge & ~down_edge & ~mode_edge;
  assign down_only = down_edge & ~up_edge & ~mode_edge;

`ifdef AUTO_EXIT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  // Next-state, next-pulse and pending-carry logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    ctl_d     = '0;
    pending_d = pending_q;

    unique case (state_q)
      S_RUN: begin
        // A live carry and a deferred one collapse into a single day step.
        if (hour_carry || pending_q) begin
          if (day_is_last) begin
            ctl_d.preset_d = 1'b1;
            ctl_d.en_m     = 1'b1;
          end else begin
            ctl_d.en_d = 1'b1;
          end
        end
        pending_d = 1'b0;
        if (mode_edge) state_d = S_SET_DAY;
      end
      S_SET_DAY: begin
        if (mode_edge) begin
          state_d = S_SET_MONTH;
        end else if (up_only) begin
          if (day_is_last) ctl_d.preset_d = 1'b1;
          else             ctl_d.up_d     = 1'b1;
        end else if (down_only && !day_is_first) begin
          ctl_d.down_d = 1'b1;
        end
      end
      S_SET_MONTH: begin
        if (mode_edge)      state_d      = S_SET_YEAR;
        else if (up_only)   ctl_d.up_m   = 1'b1;
        else if (down_only) ctl_d.down_m = 1'b1;
      end
      S_SET_YEAR: begin
        if (mode_edge)      state_d      = S_CLAMP;
        else if (up_only)   ctl_d.up_y   = 1'b1;
        else if (down_only) ctl_d.down_y = 1'b1;
      end
      S_CLAMP: begin
        // Month or leap may have changed under the day; pull it back to 01.
        if (day_too_big) ctl_d.preset_d = 1'b1;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // Rollovers while editing are remembered and replayed back in RUN.
    if (hour_carry && (state_q != S_RUN)) pending_d = 1'b1;

`ifdef AUTO_EXIT_EN
    cnt_d = '0;
    if ((state_q == S_SET_DAY) || (state_q == S_SET_MONTH) ||
        (state_q == S_SET_YEAR)) begin
      if (|btn_edge) begin
        cnt_d = '0;
      end else if (cnt_q >= (TIMEOUT_CYC - 32'd1)) begin
        cnt_d   = '0;
        state_d = S_CLAMP;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
`endif
  end

  // State, pulse, pending and button-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      ctl_q     <= '0;
      pending_q <= 1'b0;
      // History starts high so a button held through reset release is not
      // mistaken for a fresh press.
      btn_q     <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      pending_q <= pending_d;
      btn_q     <= btn_now;
    end
  end

`ifdef AUTO_EXIT_EN
  // Idle counter for the set-mode timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Mode code seen by the display; CLAMP shares the SET_YEAR code.
  always_comb begin
    mode = 2'b00;
    unique case (state_q)
      S_RUN:       mode = 2'b00;
      S_SET_DAY:   mode = 2'b01;
      S_SET_MONTH: mode = 2'b10;
      S_SET_YEAR:  mode = 2'b11;
      S_CLAMP:     mode = 2'b11;
      default:     mode = 2'b00;
    endcase
  end

  assign en_d     = ctl_q.en_d;
  assign preset_d = ctl_q.preset_d;
  assign up_d     = ctl_q.up_d;
  assign down_d   = ctl_q.down_d;
  assign en_m     = ctl_q.en_m;
  assign up_m     = ctl_q.up_m;
  assign down_m   = ctl_q.down_m;
  assign up_y     = ctl_q.up_y;
  assign down_y   = ctl_q.down_y;

endmodule
